// File: rtl/hmac_seq_pkg.sv
// Shared types and sizing constants for the HMAC-SHA384 message sequencer.
//   seq_state_e : sequencer FSM states
//   pad_mode_e  : padding overlay selection for hmac_pad_gen
package hmac_seq_pkg;

  localparam int unsigned BLOCK_W       = 1024;
  localparam int unsigned WORDS_PER_BLK = 32;
  localparam int unsigned IPAD_BYTES    = 128;
  localparam int unsigned LEN_FIELD_W   = 128;
  localparam int unsigned PAD_LIMIT     = 111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT_BSY,
    S_WAIT_RDY,
    S_PAD,
    S_DONE
  } seq_state_e;

  typedef enum logic [1:0] {
    PAD_IN_PLACE,
    PAD_80_ONLY,
    PAD_LEN_ONLY
  } pad_mode_e;

endpackage

// File: rtl/hmac_msg_sequencer_if.sv
// Byte-granular 32-bit message word stream.
//   msg_valid / msg_ready : handshake, word moves when both are high
//   msg_data              : big-endian bytes, byte 0 = [31:24]
//   msg_last              : final word of the message
//   msg_bytes             : valid bytes (0..4) in the final word
// master = word source (register/DMA layer), slave = hmac_msg_sequencer.
interface hmac_msg_sequencer_if;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_data;
  logic        msg_last;
  logic [2:0]  msg_bytes;

  modport master (output msg_valid, msg_data, msg_last, msg_bytes, input msg_ready);
  modport slave  (input msg_valid, msg_data, msg_last, msg_bytes, output msg_ready);
endinterface

// File: rtl/hmac_pad_gen.sv
// Combinational SHA-384 padding overlay.
//   i_off     : tail byte offset (position of the 0x80 marker)
//   i_count   : message byte count (ipad block added here for the length)
//   i_mode    : in_place (0x80 + length), pad80_only, len_only
//   o_mask    : per-byte keep mask, bit i = byte i (byte 0 = block MSB)
//   o_overlay : padding bytes to OR onto the masked buffer
module hmac_pad_gen
  import hmac_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic [6:0]            i_off,
  input  logic [LEN_W-1:0]      i_count,
  input  pad_mode_e             i_mode,
  output logic [IPAD_BYTES-1:0] o_mask,
  output logic [BLOCK_W-1:0]    o_overlay
);

  logic [LEN_FIELD_W-1:0] w_len;
  logic [9:0]             w_lsb;

  always_comb begin
    w_len     = (LEN_FIELD_W'(i_count) + LEN_FIELD_W'(IPAD_BYTES)) << 3;
    w_lsb     = {7'd127 - i_off, 3'b000};
    o_mask    = '0;
    o_overlay = '0;
    if (i_mode != PAD_LEN_ONLY) begin
      for (int unsigned i = 0; i < IPAD_BYTES; i++) begin
        o_mask[i] = (i < 32'(i_off));
      end
      o_overlay[w_lsb +: 8] = 8'h80;
    end
    if (i_mode != PAD_80_ONLY) begin
      o_overlay[LEN_FIELD_W-1:0] = w_len;
    end
  end

endmodule

// File: rtl/hmac_msg_sequencer.sv
// Front-end initiator for hmac_core (HMAC-SHA384): packs the word stream
// into 1024-bit blocks, applies padding and issues init/next commands.
//   clk, reset        : clock, synchronous active-high reset
//   key_i / core_key_o: HMAC key pass-through
//   start_i           : begin a message (only while busy_o=0)
//   msg               : word stream (slave side)
//   core_*            : hmac_core command/block/tag handshake
//   tag_o/tag_valid_o : captured tag and one-cycle update pulse
//   busy_o, len_err_o : message in flight, sticky byte counter overflow
module hmac_msg_sequencer
  import hmac_seq_pkg::*;
#(
  parameter int unsigned LEN_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [383:0]         key_i,
  input  logic                 start_i,
  hmac_msg_sequencer_if.slave  msg,
  output logic                 core_init_o,
  output logic                 core_next_o,
  output logic [BLOCK_W-1:0]   core_block_o,
  output logic [383:0]         core_key_o,
  input  logic                 core_ready_i,
  input  logic [383:0]         core_tag_i,
  input  logic                 core_tag_valid_i,
  output logic [383:0]         tag_o,
  output logic                 tag_valid_o,
  output logic                 busy_o,
  output logic                 len_err_o
);

  seq_state_e          r_state;
  logic [BLOCK_W-1:0]  r_buf, r_blk;
  logic [4:0]          r_idx;
  logic [LEN_W-1:0]    r_count;
  logic                r_first, r_more, r_pend80, r_pendlen;
  logic                r_ready, r_init, r_next, r_tag_valid, r_busy, r_len_err;
  logic [383:0]        r_tag;

  logic                  w_accept, w_last_full, w_boundary, w_spill;
  logic [2:0]            w_add;
  logic [LEN_W:0]        w_sum;
  logic [6:0]            w_tail, w_pad_off;
  logic [9:0]            w_slot;
  logic [LEN_W-1:0]      w_pad_cnt;
  pad_mode_e             w_pad_mode;
  logic [IPAD_BYTES-1:0] w_mask;
  logic [BLOCK_W-1:0]    w_buf_wr, w_keep, w_overlay, w_fin;

  always_comb begin
    w_accept    = (r_state == S_FILL) && r_ready && msg.msg_valid;
    w_add       = msg.msg_last ? msg.msg_bytes : 3'd4;
    w_sum       = {1'b0, r_count} + {{(LEN_W-2){1'b0}}, w_add};
    w_tail      = w_sum[6:0];
    w_last_full = (r_idx == 5'(WORDS_PER_BLK-1));
    w_boundary  = w_last_full && (w_tail == '0);
    w_spill     = 32'(w_tail) > PAD_LIMIT;
    w_slot      = {5'(WORDS_PER_BLK-1) - r_idx, 5'b00000};
    w_buf_wr    = r_buf;
    if (w_accept) begin
      w_buf_wr[w_slot +: 32] = msg.msg_data;
    end
    // PAD blocks start from the cleared buffer, so offset 0 with in_place
    // yields 0x80 + zeros + length, len_only yields zeros + length.
    if (r_state == S_PAD) begin
      w_pad_off  = '0;
      w_pad_cnt  = r_count;
      w_pad_mode = r_pend80 ? PAD_IN_PLACE : PAD_LEN_ONLY;
    end else begin
      w_pad_off  = w_tail;
      w_pad_cnt  = w_sum[LEN_W-1:0];
      w_pad_mode = w_spill ? PAD_80_ONLY : PAD_IN_PLACE;
    end
  end

  hmac_pad_gen #(.LEN_W(LEN_W)) u_pad (
    .i_off     (w_pad_off),
    .i_count   (w_pad_cnt),
    .i_mode    (w_pad_mode),
    .o_mask    (w_mask),
    .o_overlay (w_overlay)
  );

  // Keep mask also drops the don't-care bytes of a short final word.
  always_comb begin
    w_keep = '0;
    for (int unsigned i = 0; i < IPAD_BYTES; i++) begin
      w_keep[(IPAD_BYTES-1-i)*8 +: 8] = {8{w_mask[i]}};
    end
    w_fin = (w_buf_wr & w_keep) | w_overlay;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_blk       <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_first     <= 1'b1;
      r_more      <= 1'b0;
      r_pend80    <= 1'b0;
      r_pendlen   <= 1'b0;
      r_ready     <= 1'b0;
      r_init      <= 1'b0;
      r_next      <= 1'b0;
      r_tag_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_len_err   <= 1'b0;
      r_tag       <= '0;
    end else begin
      r_init      <= 1'b0;
      r_next      <= 1'b0;
      r_tag_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state   <= S_FILL;
            r_ready   <= 1'b1;
            r_busy    <= 1'b1;
            r_count   <= '0;
            r_len_err <= 1'b0;
            r_tag     <= '0;
            r_first   <= 1'b1;
            r_idx     <= '0;
            r_buf     <= '0;
            r_more    <= 1'b0;
            r_pend80  <= 1'b0;
            r_pendlen <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_count <= w_sum[LEN_W-1:0];
            if (w_sum[LEN_W]) r_len_err <= 1'b1;
            if (msg.msg_last) begin
              r_ready <= 1'b0;
              r_more  <= 1'b0;
              r_state <= S_ISSUE;
              if (w_boundary) begin
                r_blk    <= w_buf_wr;
                r_pend80 <= 1'b1;
              end else begin
                r_blk <= w_fin;
                if (w_spill) r_pendlen <= 1'b1;
              end
            end else if (w_last_full) begin
              r_ready <= 1'b0;
              r_more  <= 1'b1;
              r_blk   <= w_buf_wr;
              r_state <= S_ISSUE;
            end else begin
              r_buf <= w_buf_wr;
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        S_ISSUE: begin
          if (core_ready_i) begin
            if (r_first) r_init <= 1'b1;
            else         r_next <= 1'b1;
            r_first <= 1'b0;
            r_state <= S_WAIT_BSY;
          end
        end
        S_WAIT_BSY: r_state <= S_WAIT_RDY;
        S_WAIT_RDY: begin
          if (core_ready_i) begin
            r_buf <= '0;
            r_idx <= '0;
            if (r_pend80 || r_pendlen) begin
              r_state <= S_PAD;
            end else if (r_more) begin
              r_ready <= 1'b1;
              r_state <= S_FILL;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_PAD: begin
          r_blk     <= w_fin;
          r_pend80  <= 1'b0;
          r_pendlen <= 1'b0;
          r_state   <= S_ISSUE;
        end
        S_DONE: begin
          if (core_tag_valid_i) begin
            r_tag       <= core_tag_i;
            r_tag_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign msg.msg_ready  = r_ready;
  assign core_init_o    = r_init;
  assign core_next_o    = r_next;
  assign core_block_o   = r_blk;
  assign core_key_o     = key_i;
  assign tag_o          = r_tag;
  assign tag_valid_o    = r_tag_valid;
  assign busy_o         = r_busy;
  assign len_err_o      = r_len_err;

endmodule

// File: tb/tb_hmac_msg_sequencer.sv
// Randomized bench for hmac_msg_sequencer: a byte-level SHA-384 padding
// model predicts every block; a simple core model answers commands.
module tb_hmac_msg_sequencer;

  localparam int unsigned LW = 10;

  typedef logic [1023:0]  blk_t;
  typedef byte unsigned   byte_q_t[$];
  typedef blk_t           blk_q_t[$];
  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic [2:0]  nb;
  } word_t;
  typedef word_t word_q_t[$];

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic [383:0] key_i = '0;
  logic         core_init_o, core_next_o;
  logic [1023:0] core_block_o;
  logic [383:0] core_key_o;
  logic         core_ready_i = 1'b1;
  logic [383:0] core_tag_i = '0;
  logic         core_tag_valid_i = 1'b0;
  logic [383:0] tag_o;
  logic         tag_valid_o, busy_o, len_err_o;

  hmac_msg_sequencer_if mif();

  always #5 clk = ~clk;

  hmac_msg_sequencer #(.LEN_W(LW)) dut (
    .clk              (clk),
    .reset            (reset),
    .key_i            (key_i),
    .start_i          (start_i),
    .msg              (mif),
    .core_init_o      (core_init_o),
    .core_next_o      (core_next_o),
    .core_block_o     (core_block_o),
    .core_key_o       (core_key_o),
    .core_ready_i     (core_ready_i),
    .core_tag_i       (core_tag_i),
    .core_tag_valid_i (core_tag_valid_i),
    .tag_o            (tag_o),
    .tag_valid_o      (tag_valid_o),
    .busy_o           (busy_o),
    .len_err_o        (len_err_o)
  );

  int     total = 0;
  int     bad = 0;
  blk_q_t exp_q;
  bit     skip_blk = 0;
  int     n_cmd = 0;
  int     n_tag = 0;
  int     min_busy = 1;

  task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_blk(input string nm, input blk_t act, input blk_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int w = 0; w < 32; w++) begin
        if (act[1023-32*w -: 32] !== exp[1023-32*w -: 32]) begin
          $display("FAIL %s: word %0d got %08h want %08h", nm, w,
                   act[1023-32*w -: 32], exp[1023-32*w -: 32]);
          break;
        end
      end
    end
  endtask

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Standard SHA-384 padding of the message, with the ipad block included
  // in the bit length.
  function automatic blk_q_t pad_msg(input byte_q_t m);
    byte_q_t      p;
    blk_q_t       r;
    logic [127:0] lenf;
    blk_t         b;
    p = m;
    p.push_back(8'h80);
    while ((p.size() % 128) != 112) p.push_back(8'h00);
    lenf = (128'(m.size()) + 128'd128) * 128'd8;
    for (int i = 15; i >= 0; i--) p.push_back(lenf[i*8 +: 8]);
    for (int k = 0; k < int'(p.size()) / 128; k++) begin
      b = '0;
      for (int j = 0; j < 128; j++) b[1023-8*j -: 8] = p[128*k+j];
      r.push_back(b);
    end
    return r;
  endfunction

  function automatic word_q_t make_words(input byte_q_t m);
    word_q_t     q;
    int          n, full, rem;
    logic [31:0] d;
    n = int'(m.size());
    full = n / 4;
    rem = n % 4;
    for (int k = 0; k < full; k++)
      q.push_back('{d: {m[4*k], m[4*k+1], m[4*k+2], m[4*k+3]}, last: 1'b0, nb: 3'd4});
    if (rem > 0) begin
      d = $urandom;
      for (int j = 0; j < rem; j++) d[31-8*j -: 8] = m[4*full+j];
      q.push_back('{d: d, last: 1'b1, nb: 3'(rem)});
    end else if (n == 0 || $urandom_range(0, 1) == 1) begin
      q.push_back('{d: $urandom, last: 1'b1, nb: 3'd0});
    end else begin
      q[q.size()-1].last = 1'b1;
    end
    return q;
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t m;
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  // Compare process and hmac_core stand-in, all on the falling edge.
  initial begin : mon
    logic cmd;
    logic prev_tv;
    int   busy_cnt;
    blk_t held, e;
    prev_tv = 1'b0;
    busy_cnt = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        core_ready_i = 1'b1;
        core_tag_valid_i = 1'b0;
        busy_cnt = 0;
        prev_tv = 1'b0;
        if (core_init_o || core_next_o) check("cmd_in_reset", 384'(1), 384'(0));
      end else begin
        cmd = core_init_o | core_next_o;
        if (cmd) begin
          check("cmd_onehot", 384'(core_init_o & core_next_o), 384'(0));
          check("cmd_while_busy", 384'(core_ready_i), 384'(1));
          check("cmd_kind_init", 384'(core_init_o), 384'(n_cmd == 0));
          if (exp_q.size() == 0) begin
            check("extra_cmd", 384'(1), 384'(0));
          end else begin
            e = exp_q.pop_front();
            if (!skip_blk) check_blk("block", core_block_o, e);
          end
          n_cmd++;
          held = core_block_o;
          core_ready_i = 1'b0;
          core_tag_valid_i = 1'b0;
          busy_cnt = $urandom_range(min_busy, min_busy + 4);
        end else if (!core_ready_i) begin
          check_blk("blk_stable", core_block_o, held);
          busy_cnt--;
          if (busy_cnt == 0) begin
            core_ready_i = 1'b1;
            core_tag_valid_i = 1'b1;
            core_tag_i = rand384();
          end
        end
        if (!busy_o) check("ready_idle", 384'(mif.msg_ready), 384'(0));
        check("key_pass", core_key_o, key_i);
        if (tag_valid_o) begin
          check("tag_val", tag_o, core_tag_i);
          check("tv_busy", 384'(busy_o), 384'(0));
          check("tv_pulse", 384'(prev_tv), 384'(0));
          check("blocks_left", 384'(exp_q.size()), 384'(0));
          n_tag++;
        end
        prev_tv = tag_valid_o;
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    check("idle_before_start", 384'(busy_o), 384'(0));
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_busy", 384'(busy_o), 384'(1));
    check("start_tag_clr", tag_o, '0);
    check("start_err_clr", 384'(len_err_o), 384'(0));
    check("start_ready", 384'(mif.msg_ready), 384'(1));
  endtask

  task automatic send_words(input word_q_t w);
    int i = 0;
    int guard = 0;
    while (i < int'(w.size()) && guard < 20000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 3) != 0) begin
        mif.msg_valid = 1'b1;
        {mif.msg_data, mif.msg_last, mif.msg_bytes} = w[i];
        if (mif.msg_ready) i++;
      end else begin
        mif.msg_valid = 1'b0;
        mif.msg_data = $urandom;
      end
      start_i = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    mif.msg_valid = 1'b0;
    start_i = 1'b0;
    if (i < int'(w.size())) check("word_timeout", 384'(i), 384'(w.size()));
  endtask

  task automatic wait_tag(input int n0);
    int guard = 0;
    while (n_tag == n0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (n_tag == n0) check("tag_timeout", 384'(0), 384'(1));
  endtask

  task automatic run_msg(input byte_q_t m, input logic [383:0] key, input bit skip, input bit exp_err);
    int n0, exp_n;
    logic [383:0] t;
    exp_q = pad_msg(m);
    exp_n = int'(exp_q.size());
    skip_blk = skip;
    n_cmd = 0;
    n0 = n_tag;
    key_i = key;
    do_start();
    send_words(make_words(m));
    wait_tag(n0);
    check("n_cmd", 384'(n_cmd), 384'(exp_n));
    check("len_err", 384'(len_err_o), 384'(exp_err));
    t = core_tag_i;
    repeat (2) @(negedge clk);
    check("tag_hold", tag_o, t);
    skip_blk = 0;
  endtask

  initial begin : main
    blk_q_t  q;
    byte_q_t m;
    mif.msg_valid = 1'b0;
    mif.msg_data  = '0;
    mif.msg_last  = 1'b0;
    mif.msg_bytes = '0;

    // Pin the padding model against hand-computed blocks.
    m = {};
    q = pad_msg(m);
    check("pin_empty_n", 384'(q.size()), 384'(1));
    check("pin_empty_w0", 384'(q[0][1023:992]), 384'(32'h80000000));
    check("pin_empty_len", 384'(q[0][127:0]), 384'(128'h400));
    m = {8'h61, 8'h62, 8'h63};
    q = pad_msg(m);
    check("pin_abc_w0", 384'(q[0][1023:992]), 384'(32'h61626380));
    check("pin_abc_len", 384'(q[0][127:0]), 384'(128'h418));
    q = pad_msg(rand_bytes(112));
    check("pin_112_n", 384'(q.size()), 384'(2));
    check("pin_112_80", 384'(q[0][1023-8*112 -: 8]), 384'(8'h80));
    check("pin_112_len", 384'(q[1][127:0]), 384'(128'h780));
    check("pin_112_zero", 384'(q[1][1023:128] == '0), 384'(1));
    q = pad_msg(rand_bytes(128));
    check("pin_128_w0", 384'(q[1][1023:992]), 384'(32'h80000000));
    check("pin_128_len", 384'(q[1][127:0]), 384'(128'h800));
    q = pad_msg(rand_bytes(300));
    check("pin_300_n", 384'(q.size()), 384'(3));
    check("pin_300_len", 384'(q[2][127:0]), 384'(128'hD60));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 384'(mif.msg_ready), 384'(0));
    check("rst_init", 384'(core_init_o), 384'(0));
    check("rst_next", 384'(core_next_o), 384'(0));
    check_blk("rst_block", core_block_o, '0);
    check("rst_tag", tag_o, '0);
    check("rst_tv", 384'(tag_valid_o), 384'(0));
    check("rst_busy", 384'(busy_o), 384'(0));
    check("rst_err", 384'(len_err_o), 384'(0));

    m = {};
    run_msg(m, {48{8'h0b}}, 0, 0);
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, rand384(), 0, 0);
    run_msg(rand_bytes(112), rand384(), 0, 0);
    run_msg(rand_bytes(128), rand384(), 0, 0);
    run_msg(rand_bytes(300), rand384(), 0, 0);

    // Reset while the second block is in flight.
    begin
      int guard = 0;
      m = rand_bytes(200);
      exp_q = pad_msg(m);
      n_cmd = 0;
      min_busy = 4;
      key_i = rand384();
      do_start();
      send_words(make_words(m));
      while (n_cmd < 2 && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      if (n_cmd < 2) check("rst_test_timeout", 384'(n_cmd), 384'(2));
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      min_busy = 1;
      @(negedge clk);
      check("mid_rst_ready", 384'(mif.msg_ready), 384'(0));
      check("mid_rst_cmd", 384'(core_init_o | core_next_o), 384'(0));
      check_blk("mid_rst_block", core_block_o, '0);
      check("mid_rst_tag", tag_o, '0);
      check("mid_rst_busy", 384'(busy_o), 384'(0));
      check("mid_rst_err", 384'(len_err_o), 384'(0));
      repeat (3) @(negedge clk);
      m = {8'h61, 8'h62, 8'h63};
      run_msg(m, rand384(), 0, 0);
    end

    foreach (q[i]) q[i] = '0;
    begin
      int lens[10] = '{111, 112, 124, 125, 127, 239, 240, 256, 4, 1};
      foreach (lens[i]) run_msg(rand_bytes(lens[i]), rand384(), 0, 0);
    end
    for (int k = 0; k < 8; k++) run_msg(rand_bytes($urandom_range(0, 400)), rand384(), 0, 0);

    // Byte counter wraps at 2^LW: sequence completes, error flag sticks.
    run_msg(rand_bytes(1030), rand384(), 1, 1);
    run_msg(rand_bytes(20), rand384(), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
